// File: rtl/rock_driver_pkg.sv
// Shared types and constants for the cradle rocking driver.
package rock_driver_pkg;

  localparam int unsigned AF_W          = 4;
  localparam int unsigned POS_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    SWING_POS,
    SWING_NEG,
    RETURN
  } state_t;

endpackage

// File: rtl/rock_driver_step_timer.sv
// Base-tick prescaler plus (16 - F_l) tick interval counter producing step_fire.
module rock_driver_step_timer
  import rock_driver_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [AF_W-1:0] F_l,
  output logic            step_fire
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_W-1:0] presc;
  logic [AF_W-1:0]  ivl;
  logic             tick;
  logic [AF_W-1:0]  last;

  assign tick = (presc == PRE_W'(CLK_DIV - 1));
  // Index of the final tick in a (16 - F_l) tick interval is 15 - F_l.
  assign last      = ~F_l;
  assign step_fire = tick & (ivl == last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      ivl   <= '0;
    end else if (clear) begin
      presc <= '0;
      ivl   <= '0;
    end else if (tick) begin
      presc <= '0;
      ivl   <= step_fire ? '0 : ivl + AF_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

endmodule

// File: rtl/rock_driver.sv
// Rocking cradle driver: turns latched amplitude/frequency into a symmetric
// step stream around centre, relatching at centre crossings and parking on stop.
module rock_driver
  import rock_driver_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 1000,
  parameter int unsigned STEPS_PER_A = 4,
  parameter int unsigned POS_W       = POS_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [AF_W-1:0]         A,
  input  logic [AF_W-1:0]         F,
  input  logic                    AF0,
  output logic                    step,
  output logic                    dir,
  output logic signed [POS_W-1:0] pos,
  output logic                    busy,
  output logic                    cycle_done
);

  state_t                  state;
  logic [AF_W-1:0]         A_l;
  logic [AF_W-1:0]         F_l;
  logic                    step_fire;
  logic                    clear;
  logic                    stop_req;
  logic                    swinging;
  logic [POS_W-1:0]        limit;
  logic signed [POS_W-1:0] limit_s;
  logic signed [POS_W-1:0] pos_n;

  assign stop_req = AF0 | ~enable;
  assign swinging = (state == SWING_POS) || (state == SWING_NEG);
  assign limit    = POS_W'(A_l) * POS_W'(STEPS_PER_A);
  assign limit_s  = $signed(limit);
  assign pos_n    = dir ? POS_W'(pos + 1) : POS_W'(pos - 1);

  // Interval restarts while idle and when a swing is abandoned between steps.
  assign clear = (state == IDLE) | (swinging & stop_req & ~step_fire);

  rock_driver_step_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .F_l       (F_l),
    .step_fire (step_fire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step       <= 1'b0;
      dir        <= 1'b1;
      pos        <= '0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
      A_l        <= '0;
      F_l        <= '0;
    end else begin
      step       <= 1'b0;
      cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          pos <= '0;
          dir <= 1'b1;
          if (enable && !AF0 && (A != '0)) begin
            A_l   <= A;
            F_l   <= F;
            state <= SWING_POS;
            busy  <= 1'b1;
          end
        end
        SWING_POS, SWING_NEG: begin
          if (step_fire) begin
            step <= 1'b1;
            pos  <= pos_n;
            // Centre crossing: stop wins over relatching new A/F.
            if ((state == SWING_POS) && (pos_n == '0)) begin
              cycle_done <= 1'b1;
              if (stop_req || (A == '0)) begin
                state <= IDLE;
                busy  <= 1'b0;
                dir   <= 1'b1;
              end else begin
                A_l <= A;
                F_l <= F;
              end
            end else if ((state == SWING_POS) && (pos_n == limit_s)) begin
              state <= SWING_NEG;
              dir   <= 1'b0;
            end else if ((state == SWING_NEG) && (pos_n == -limit_s)) begin
              state <= SWING_POS;
              dir   <= 1'b1;
            end
          end else if (stop_req) begin
            if (pos == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
              dir   <= 1'b1;
            end else begin
              state <= RETURN;
              dir   <= pos[POS_W-1];
            end
          end
        end
        RETURN: begin
          if (step_fire) begin
            step <= 1'b1;
            pos  <= pos_n;
            if (pos_n == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
              dir   <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rock_driver.sv
// Directed bench for rock_driver with CLK_DIV=2, STEPS_PER_A=4, POS_W=8.
module tb_rock_driver;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [3:0]        A;
  logic [3:0]        F;
  logic              AF0;
  logic              step;
  logic              dir;
  logic signed [7:0] pos;
  logic              busy;
  logic              cycle_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rock_driver #(
    .CLK_DIV     (2),
    .STEPS_PER_A (4),
    .POS_W       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .A          (A),
    .F          (F),
    .AF0        (AF0),
    .step       (step),
    .dir        (dir),
    .pos        (pos),
    .busy       (busy),
    .cycle_done (cycle_done)
  );

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; A = 4'd0; F = 4'd0; AF0 = 1'b1;
    #12;
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %0b want 0", step); end
    n_checks++; if (dir !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %0b want 1", dir); end
    n_checks++; if (pos !== 8'sd0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", pos); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (cycle_done !== 1'b0) begin n_fail++; $display("FAIL reset_cd: got %0b want 0", cycle_done); end
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_basic_swing();
    int exp_pos[16] = '{1, 2, 3, 4, 3, 2, 1, 0, -1, -2, -3, -4, -3, -2, -1, 0};
    int k = 0;
    A = 4'd1; F = 4'd15; AF0 = 1'b0; enable = 1'b1;
    wait_cycle();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", busy); end
    n_checks++; if (pos !== 8'sd0) begin n_fail++; $display("FAIL basic_pos0: got %0d want 0", pos); end
    for (int c = 1; c <= 32; c++) begin
      wait_cycle();
      if (c % 2 == 0) begin
        k++;
        n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL basic_step c=%0d: got %0b want 1", c, step); end
        n_checks++; if (int'(pos) != exp_pos[k-1]) begin n_fail++; $display("FAIL basic_pos k=%0d: got %0d want %0d", k, pos, exp_pos[k-1]); end
        n_checks++; if (dir !== ((k < 4) || (k >= 12))) begin n_fail++; $display("FAIL basic_dir k=%0d: got %0b want %0b", k, dir, ((k < 4) || (k >= 12))); end
        n_checks++; if (cycle_done !== (k == 16)) begin n_fail++; $display("FAIL basic_cd k=%0d: got %0b want %0b", k, cycle_done, (k == 16)); end
      end else begin
        n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL basic_nostep c=%0d: got %0b want 0", c, step); end
      end
    end
    enable = 1'b0;
    wait_cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_park_busy: got %0b want 0", busy); end
  endtask

  task automatic test_slow_swing();
    int bad = 0, nsteps = 0, pmax = 0, pmin = 0, cd_at = -1;
    A = 4'd2; F = 4'd0; AF0 = 1'b0; enable = 1'b1;
    wait_cycle();
    for (int c = 1; c <= 1024; c++) begin
      wait_cycle();
      if (step === 1'b1) nsteps++;
      if (step !== (c % 32 == 0)) bad++;
      if (int'(pos) > pmax) pmax = int'(pos);
      if (int'(pos) < pmin) pmin = int'(pos);
      if (cycle_done === 1'b1) cd_at = c;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL slow_spacing: got %0d misplaced steps want 0", bad); end
    n_checks++; if (nsteps != 32) begin n_fail++; $display("FAIL slow_nsteps: got %0d want 32", nsteps); end
    n_checks++; if (pmax != 8) begin n_fail++; $display("FAIL slow_pmax: got %0d want 8", pmax); end
    n_checks++; if (pmin != -8) begin n_fail++; $display("FAIL slow_pmin: got %0d want -8", pmin); end
    n_checks++; if (cd_at != 1024) begin n_fail++; $display("FAIL slow_cd_at: got %0d want 1024", cd_at); end
    enable = 1'b0;
    wait_cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL slow_park_busy: got %0b want 0", busy); end
  endtask

  task automatic test_amp_latch();
    int pmax1 = 0, pmin1 = 0, pmax2 = 0, pmin2 = 0, ncd = 0;
    A = 4'd1; F = 4'd15; AF0 = 1'b0; enable = 1'b1;
    wait_cycle();
    for (int c = 1; c <= 128; c++) begin
      wait_cycle();
      if (c == 4) begin
        n_checks++; if (pos !== 8'sd2) begin n_fail++; $display("FAIL latch_pos2: got %0d want 2", pos); end
        A = 4'd3;
      end
      if (c <= 32) begin
        if (int'(pos) > pmax1) pmax1 = int'(pos);
        if (int'(pos) < pmin1) pmin1 = int'(pos);
      end else begin
        if (int'(pos) > pmax2) pmax2 = int'(pos);
        if (int'(pos) < pmin2) pmin2 = int'(pos);
      end
      if (cycle_done === 1'b1) ncd++;
      if (c == 128) begin
        n_checks++; if (cycle_done !== 1'b1) begin n_fail++; $display("FAIL latch_cd128: got %0b want 1", cycle_done); end
      end
    end
    n_checks++; if (pmax1 != 4) begin n_fail++; $display("FAIL latch_pmax1: got %0d want 4", pmax1); end
    n_checks++; if (pmin1 != -4) begin n_fail++; $display("FAIL latch_pmin1: got %0d want -4", pmin1); end
    n_checks++; if (pmax2 != 12) begin n_fail++; $display("FAIL latch_pmax2: got %0d want 12", pmax2); end
    n_checks++; if (pmin2 != -12) begin n_fail++; $display("FAIL latch_pmin2: got %0d want -12", pmin2); end
    n_checks++; if (ncd != 2) begin n_fail++; $display("FAIL latch_ncd: got %0d want 2", ncd); end
    enable = 1'b0; A = 4'd1;
    wait_cycle();
  endtask

  task automatic test_stop_return();
    int nsteps = 0, ncd = 0, last_c = -1, bad_dir = 0, bad_pos = 0;
    A = 4'd1; F = 4'd15; AF0 = 1'b0; enable = 1'b1;
    wait_cycle();
    for (int c = 1; c <= 22; c++) wait_cycle();
    n_checks++; if (pos !== -8'sd3) begin n_fail++; $display("FAIL ret_pos_m3: got %0d want -3", pos); end
    enable = 1'b0;
    wait_cycle();
    n_checks++; if (dir !== 1'b1) begin n_fail++; $display("FAIL ret_dir: got %0b want 1", dir); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ret_busy: got %0b want 1", busy); end
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL ret_entry_step: got %0b want 0", step); end
    for (int c = 24; c <= 43; c++) begin
      wait_cycle();
      if (step === 1'b1) begin
        nsteps++;
        last_c = c;
        if (int'(pos) != -3 + nsteps) bad_pos++;
        if (dir !== 1'b1) bad_dir++;
      end
      if (cycle_done === 1'b1) ncd++;
    end
    n_checks++; if (nsteps != 3) begin n_fail++; $display("FAIL ret_nsteps: got %0d want 3", nsteps); end
    n_checks++; if (last_c != 29) begin n_fail++; $display("FAIL ret_last_step: got cycle %0d want 29", last_c); end
    n_checks++; if (bad_pos != 0) begin n_fail++; $display("FAIL ret_step_pos: got %0d wrong want 0", bad_pos); end
    n_checks++; if (bad_dir != 0) begin n_fail++; $display("FAIL ret_step_dir: got %0d wrong want 0", bad_dir); end
    n_checks++; if (ncd != 0) begin n_fail++; $display("FAIL ret_cd: got %0d pulses want 0", ncd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ret_idle_busy: got %0b want 0", busy); end
    n_checks++; if (pos !== 8'sd0) begin n_fail++; $display("FAIL ret_idle_pos: got %0d want 0", pos); end
  endtask

  task automatic test_stop_at_centre();
    int nsteps = 0, ncd = 0, nbusy = 0;
    A = 4'd1; F = 4'd15; AF0 = 1'b0; enable = 1'b1;
    wait_cycle();
    for (int c = 1; c <= 30; c++) wait_cycle();
    n_checks++; if (pos !== -8'sd1) begin n_fail++; $display("FAIL ctr_pos_m1: got %0d want -1", pos); end
    wait_cycle();
    AF0 = 1'b1;
    wait_cycle();
    n_checks++; if (step !== 1'b1) begin n_fail++; $display("FAIL ctr_step: got %0b want 1", step); end
    n_checks++; if (pos !== 8'sd0) begin n_fail++; $display("FAIL ctr_pos: got %0d want 0", pos); end
    n_checks++; if (cycle_done !== 1'b1) begin n_fail++; $display("FAIL ctr_cd: got %0b want 1", cycle_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ctr_busy: got %0b want 0", busy); end
    for (int c = 0; c < 20; c++) begin
      wait_cycle();
      if (step === 1'b1) nsteps++;
      if (cycle_done === 1'b1) ncd++;
      if (busy === 1'b1) nbusy++;
    end
    n_checks++; if (nsteps != 0) begin n_fail++; $display("FAIL ctr_after_steps: got %0d want 0", nsteps); end
    n_checks++; if (ncd != 0) begin n_fail++; $display("FAIL ctr_after_cd: got %0d want 0", ncd); end
    n_checks++; if (nbusy != 0) begin n_fail++; $display("FAIL ctr_after_busy: got %0d want 0", nbusy); end
  endtask

  task automatic test_zero_amp();
    int nsteps = 0, nbusy = 0;
    A = 4'd0; F = 4'd5; AF0 = 1'b0; enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      wait_cycle();
      if (step === 1'b1) nsteps++;
      if (busy === 1'b1) nbusy++;
    end
    n_checks++; if (nsteps != 0) begin n_fail++; $display("FAIL zero_steps: got %0d want 0", nsteps); end
    n_checks++; if (nbusy != 0) begin n_fail++; $display("FAIL zero_busy: got %0d want 0", nbusy); end
  endtask

  task automatic test_reset_mid();
    A = 4'd1; F = 4'd15; AF0 = 1'b0; enable = 1'b1;
    wait_cycle();
    for (int c = 1; c <= 10; c++) wait_cycle();
    n_checks++; if (pos !== 8'sd3) begin n_fail++; $display("FAIL rmid_pre_pos: got %0d want 3", pos); end
    n_checks++; if (dir !== 1'b0) begin n_fail++; $display("FAIL rmid_pre_dir: got %0b want 0", dir); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL rmid_step: got %0b want 0", step); end
    n_checks++; if (dir !== 1'b1) begin n_fail++; $display("FAIL rmid_dir: got %0b want 1", dir); end
    n_checks++; if (pos !== 8'sd0) begin n_fail++; $display("FAIL rmid_pos: got %0d want 0", pos); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    n_checks++; if (cycle_done !== 1'b0) begin n_fail++; $display("FAIL rmid_cd: got %0b want 0", cycle_done); end
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cycle();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_after_busy: got %0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic_swing();
    test_slow_swing();
    test_amp_latch();
    test_stop_return();
    test_stop_at_centre();
    test_zero_amp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
